// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing and receiver types. The driver and the receiver
// both take their bit timing from here so that loopback stays consistent.
package ws2812_pkg;

  // Receiver decode states
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,  // waiting for a full latch gap before trusting the line
    ST_IDLE = 2'd1,  // gap seen, waiting for the first rise of a frame
    ST_HIGH = 2'd2,  // measuring a high pulse
    ST_LOW  = 2'd3   // measuring the low time after a bit
  } rx_state_e;

  // Line timing in clk cycles at 24 MHz
  localparam int T1H          = 20;
  localparam int T1L          = 11;
  localparam int T0H          = 10;
  localparam int T0L          = 21;
  localparam int HIGH_THRESH  = 14;
  localparam int MIN_HIGH     = 4;
  localparam int MAX_HIGH     = 40;
  localparam int LATCH_CYCLES = 1200;
  localparam int CNT_W        = 12;
  localparam int WORD_W       = 24;

  // Pixel counter increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] pix_sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus one extra
// delay stage for rise/fall detection. Both edges see the same delay, so
// pulse widths measured downstream match the widths on the pin.
module ws2812_rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic ds_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic ds_q;
  logic dq_q;

  // Synchronizer chain and one-cycle delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      ds_q   <= 1'b0;
      dq_q   <= 1'b0;
    end else begin
      meta_q <= din_i;
      ds_q   <= meta_q;
      dq_q   <= ds_q;
    end
  end

  assign ds_o   = ds_q;
  assign rise_o = ds_q & ~dq_q;
  assign fall_o = ~ds_q & dq_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder. Classifies each high pulse as a 0 or 1
// by its width, assembles MSB-first 24-bit words, counts pixels per frame
// and detects the latch gap that closes a frame. Any protocol violation
// drops the partial word and forces a resync on a full latch gap.
module ws2812_rx #(
  parameter int HIGH_THRESH  = ws2812_pkg::HIGH_THRESH,
  parameter int MIN_HIGH     = ws2812_pkg::MIN_HIGH,
  parameter int MAX_HIGH     = ws2812_pkg::MAX_HIGH,
  parameter int LATCH_CYCLES = ws2812_pkg::LATCH_CYCLES,
  parameter int CNT_W        = ws2812_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_i,
  output logic [23:0] rgb_o,
  output logic        rgb_valid_o,
  output logic        frame_end_o,
  output logic [7:0]  pixel_count_o,
  output logic        err_o
);

  import ws2812_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C     = CNT_W'(HIGH_THRESH);
  localparam logic [CNT_W-1:0] MIN_HIGH_C   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_HIGH_C   = CNT_W'(MAX_HIGH);
  // Compared against the count before increment, so the cycle that would
  // bring the count to LATCH_CYCLES is the one that fires.
  localparam logic [CNT_W-1:0] LATCH_LAST_C = CNT_W'(LATCH_CYCLES - 1);

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX_C) begin
      return v;
    end else begin
      return v + CNT_ONE_C;
    end
  endfunction

  logic ds_s;
  logic rise_s;
  logic fall_s;

  ws2812_rx_sync_edge u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .din_i  (din_i),
    .ds_o   (ds_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  rx_state_e        state_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] gap_q;
  logic [4:0]       bitcnt_q;
  logic [22:0]      shift_q;
  logic [23:0]      rgb_q;
  logic             rgb_valid_q;
  logic             frame_end_q;
  logic [7:0]       pixel_count_q;
  logic             err_q;

  logic             bit_s;
  logic [23:0]      word_d;
  logic             last_bit_s;

  // Bit decision for the pulse that just ended and the word it completes
  always_comb begin
    bit_s      = (hcnt_q >= THRESH_C);
    word_d     = {shift_q, bit_s};
    last_bit_s = (bitcnt_q == 5'd23);
  end

  // Decode FSM with pulse/gap counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      hcnt_q        <= CNT_ZERO_C;
      gap_q         <= CNT_ZERO_C;
      bitcnt_q      <= 5'd0;
      shift_q       <= 23'd0;
      rgb_q         <= 24'd0;
      rgb_valid_q   <= 1'b0;
      frame_end_q   <= 1'b0;
      pixel_count_q <= 8'd0;
      err_q         <= 1'b0;
    end else begin
      rgb_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (ds_s) begin
            gap_q <= CNT_ZERO_C;
          end else if (gap_q == LATCH_LAST_C) begin
            gap_q   <= CNT_ZERO_C;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= cnt_inc(gap_q);
          end
        end
        ST_IDLE: begin
          if (rise_s) begin
            state_q       <= ST_HIGH;
            hcnt_q        <= CNT_ONE_C;
            pixel_count_q <= 8'd0;
            bitcnt_q      <= 5'd0;
          end else begin
            hcnt_q <= CNT_ZERO_C;
          end
        end
        ST_HIGH: begin
          if (ds_s) begin
            if (hcnt_q == MAX_HIGH_C) begin
              // Line stuck high past the longest legal pulse
              err_q    <= 1'b1;
              bitcnt_q <= 5'd0;
              gap_q    <= CNT_ZERO_C;
              state_q  <= ST_SYNC;
            end else begin
              hcnt_q <= cnt_inc(hcnt_q);
            end
          end else if (fall_s) begin
            if (hcnt_q < MIN_HIGH_C) begin
              // Glitch: too short to be a bit
              err_q    <= 1'b1;
              bitcnt_q <= 5'd0;
              gap_q    <= CNT_ZERO_C;
              state_q  <= ST_SYNC;
            end else begin
              shift_q <= word_d[22:0];
              gap_q   <= CNT_ONE_C;
              state_q <= ST_LOW;
              if (last_bit_s) begin
                rgb_q         <= word_d;
                rgb_valid_q   <= 1'b1;
                pixel_count_q <= pix_sat_inc(pixel_count_q);
                bitcnt_q      <= 5'd0;
              end else begin
                bitcnt_q <= bitcnt_q + 5'd1;
              end
            end
          end else begin
            // Low without a seen falling edge cannot be trusted; resync
            err_q    <= 1'b1;
            bitcnt_q <= 5'd0;
            gap_q    <= CNT_ZERO_C;
            state_q  <= ST_SYNC;
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            hcnt_q  <= CNT_ONE_C;
            state_q <= ST_HIGH;
          end else if (gap_q == LATCH_LAST_C) begin
            // Latch gap ends the frame; a partial word is a violation
            frame_end_q <= 1'b1;
            err_q       <= (bitcnt_q != 5'd0);
            bitcnt_q    <= 5'd0;
            gap_q       <= CNT_ZERO_C;
            state_q     <= ST_IDLE;
          end else begin
            gap_q <= cnt_inc(gap_q);
          end
        end
        default: begin
          state_q  <= ST_SYNC;
          gap_q    <= CNT_ZERO_C;
          bitcnt_q <= 5'd0;
        end
      endcase
    end
  end

  assign rgb_o         = rgb_q;
  assign rgb_valid_o   = rgb_valid_q;
  assign frame_end_o   = frame_end_q;
  assign pixel_count_o = pixel_count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: expected words are queued as they are
// sent and compared when rgb_valid strobes; event counters cover err,
// frame_end and their coincidence.
module tb_ws2812_rx;

  logic        clk;
  logic        rst;
  logic        din;
  logic [23:0] rgb_o;
  logic        rgb_valid_o;
  logic        frame_end_o;
  logic [7:0]  pixel_count_o;
  logic        err_o;

  ws2812_rx dut (
    .clk           (clk),
    .rst           (rst),
    .din_i         (din),
    .rgb_o         (rgb_o),
    .rgb_valid_o   (rgb_valid_o),
    .frame_end_o   (frame_end_o),
    .pixel_count_o (pixel_count_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and monitor-owned event counters
  logic [23:0] exp_q[$];
  logic [23:0] exp_w;
  int valid_cnt = 0;
  int err_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int clash_cnt = 0;
  int mon_bad = 0;

  // Bench-owned counters and snapshots
  int pass_cnt = 0;
  int total_cnt = 0;
  int v0, e0, f0, b0, m0;
  int err_at;

  // Monitor: compare each strobed word against the scoreboard
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (rgb_valid_o === 1'b1) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rgb_unexpected got %06h want no strobe", rgb_o);
          mon_bad++;
        end else begin
          exp_w = exp_q.pop_front();
          if (rgb_o !== exp_w) begin
            $display("FAIL rgb_word got %06h want %06h", rgb_o, exp_w);
            mon_bad++;
          end
        end
      end
      if (err_o === 1'b1) err_cnt++;
      if (frame_end_o === 1'b1) fe_cnt++;
      if (err_o === 1'b1 && frame_end_o === 1'b1) both_cnt++;
      if (rgb_valid_o === 1'b1 && frame_end_o === 1'b1) clash_cnt++;
    end
  end

  task automatic snap();
    v0 = valid_cnt; e0 = err_cnt; f0 = fe_cnt; b0 = both_cnt; m0 = mon_bad;
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic send_bits(input logic [23:0] w, input int from, input int to);
    for (int i = from; i >= to; i--) begin
      if (w[i]) pulse(20, 11);
      else      pulse(10, 21);
    end
  endtask

  task automatic send_word(input logic [23:0] w, input bit expect_it);
    if (expect_it) exp_q.push_back(w);
    send_bits(w, 23, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (rgb_o !== 24'h000000) $display("FAIL reset_rgb got %06h want %06h", rgb_o, 24'h0); else pass_cnt++;
    total_cnt++; if (rgb_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", rgb_valid_o); else pass_cnt++;
    total_cnt++; if (frame_end_o !== 1'b0) $display("FAIL reset_fe got %b want 0", frame_end_o); else pass_cnt++;
    total_cnt++; if (pixel_count_o !== 8'd0) $display("FAIL reset_pc got %0d want 0", pixel_count_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else pass_cnt++;
    rst = 1'b0;
    hold(1'b0, 1250);
  endtask

  task automatic test_single_word();
    snap();
    send_word(24'hA53CF0, 1'b1);
    hold(1'b0, 40);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL single_strobes got %0d want 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'hA53CF0) $display("FAIL single_rgb got %06h want %06h", rgb_o, 24'hA53CF0); else pass_cnt++;
    total_cnt++; if (pixel_count_o !== 8'd1) $display("FAIL single_pc got %0d want 1", pixel_count_o); else pass_cnt++;
    hold(1'b0, 1250);
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL single_err got %0d want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL single_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (mon_bad - m0 !== 0) $display("FAIL single_words got %0d bad want 0", mon_bad - m0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    snap();
    send_word(24'h000000, 1'b1);
    send_word(24'hFFFFFF, 1'b1);
    send_word(24'h123456, 1'b1);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 3) $display("FAIL b2b_strobes got %0d want 3", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL b2b_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL b2b_err got %0d want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (pixel_count_o !== 8'd3) $display("FAIL b2b_pc got %0d want 3", pixel_count_o); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'h123456) $display("FAIL b2b_rgb got %06h want %06h", rgb_o, 24'h123456); else pass_cnt++;
    total_cnt++; if (mon_bad - m0 !== 0) $display("FAIL b2b_words got %0d bad want 0", mon_bad - m0); else pass_cnt++;
  endtask

  // Widths 14/13/4/40 on the top four bits: decode as 1,0,0,1
  task automatic test_thresholds();
    snap();
    exp_q.push_back(24'h9ABCDE);
    hold(1'b1, 14);
    total_cnt++; if (pixel_count_o !== 8'd0) $display("FAIL thr_pc_clear got %0d want 0", pixel_count_o); else pass_cnt++;
    hold(1'b0, 17);
    pulse(13, 18);
    pulse(4, 27);
    pulse(40, 20);
    send_bits(24'h9ABCDE, 19, 0);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL thr_strobes got %0d want 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL thr_err got %0d want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'h9ABCDE) $display("FAIL thr_rgb got %06h want %06h", rgb_o, 24'h9ABCDE); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL thr_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (mon_bad - m0 !== 0) $display("FAIL thr_words got %0d bad want 0", mon_bad - m0); else pass_cnt++;
  endtask

  task automatic test_glitch();
    snap();
    send_bits(24'hFFFFFF, 23, 19);
    pulse(2, 20);
    send_bits(24'hFFFFFF, 18, 0);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL glitch_no_strobe got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL glitch_err got %0d want 1", err_cnt - e0); else pass_cnt++;
    send_word(24'h00FF00, 1'b1);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL glitch_recover got %0d want 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'h00FF00) $display("FAIL glitch_rgb got %06h want %06h", rgb_o, 24'h00FF00); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL glitch_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (mon_bad - m0 !== 0) $display("FAIL glitch_words got %0d bad want 0", mon_bad - m0); else pass_cnt++;
  endtask

  // 60 high cycles: err visible after the 41st sampling edge plus the
  // two synchronizer/decode edges, i.e. edge 43 counted from the first high
  task automatic test_stuck_high();
    snap();
    err_at = 0;
    din = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (err_o === 1'b1 && err_at == 0) err_at = i;
    end
    hold(1'b0, 100);
    total_cnt++; if (err_at !== 43) $display("FAIL stuck_err_edge got %0d want 43", err_at); else pass_cnt++;
    send_word(24'h111111, 1'b0);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL stuck_sync_ignore got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL stuck_err_cnt got %0d want 1", err_cnt - e0); else pass_cnt++;
    send_word(24'h5A5A5A, 1'b1);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL stuck_recover got %0d want 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL stuck_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'h5A5A5A) $display("FAIL stuck_rgb got %06h want %06h", rgb_o, 24'h5A5A5A); else pass_cnt++;
  endtask

  task automatic test_partial();
    snap();
    send_bits(24'hFFF000, 23, 12);
    hold(1'b0, 1250);
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL partial_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL partial_err got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (both_cnt - b0 !== 1) $display("FAIL partial_same_cycle got %0d want 1", both_cnt - b0); else pass_cnt++;
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL partial_strobes got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'h5A5A5A) $display("FAIL partial_rgb_kept got %06h want %06h", rgb_o, 24'h5A5A5A); else pass_cnt++;
  endtask

  task automatic test_rst_midword();
    snap();
    send_bits(24'hF0F0F0, 23, 14);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (rgb_o !== 24'h000000) $display("FAIL rst_rgb got %06h want %06h", rgb_o, 24'h0); else pass_cnt++;
    total_cnt++; if (pixel_count_o !== 8'd0) $display("FAIL rst_pc got %0d want 0", pixel_count_o); else pass_cnt++;
    total_cnt++; if ({rgb_valid_o, frame_end_o, err_o} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {rgb_valid_o, frame_end_o, err_o}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    send_bits(24'hF0F0F0, 13, 0);
    send_word(24'hFFFFFF, 1'b0);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL rst_ignore got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL rst_err got %0d want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL rst_fe_early got %0d want 0", fe_cnt - f0); else pass_cnt++;
    send_word(24'hC3C3C3, 1'b1);
    hold(1'b0, 1250);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL rst_recover got %0d want 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (rgb_o !== 24'hC3C3C3) $display("FAIL rst_rgb_after got %06h want %06h", rgb_o, 24'hC3C3C3); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL rst_fe got %0d want 1", fe_cnt - f0); else pass_cnt++;
  endtask

  initial begin
    din = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_thresholds();
    test_glitch();
    test_stuck_high();
    test_partial();
    test_rst_midword();
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (clash_cnt !== 0) $display("FAIL valid_fe_clash got %0d want 0", clash_cnt); else pass_cnt++;
    total_cnt++; if (mon_bad !== 0) $display("FAIL word_compare got %0d bad want 0", mon_bad); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
